// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: ALU control codes, opcode/funct
// encodings, the ID/EX control payload and the operand forwarding helper.
package alu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alucont_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;

    typedef struct packed {
        logic            regwrite;
        logic            memtoreg;
        logic            memwrite;
        logic            branch;
        logic            alusrc;
        alucont_t        alucont;
        logic [REGW-1:0] dst;
    } ex_ctrl_t;

    // Nearer producer (EX/MEM) wins over MEM/WB; register 0 never forwards.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REGW-1:0] src,
        input logic [XLEN-1:0] stored,
        input logic            near_we,
        input logic [REGW-1:0] near_dst,
        input logic [XLEN-1:0] near_val,
        input logic            far_we,
        input logic [REGW-1:0] far_dst,
        input logic [XLEN-1:0] far_val
    );
        if (near_we && (near_dst != '0) && (near_dst == src)) return near_val;
        if (far_we && (far_dst != '0) && (far_dst == src))    return far_val;
        return stored;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational instruction decoder.
//   instr   : instruction word in ID
//   ctrl    : control payload for ID/EX (all zero for bubbles/illegal)
//   imm     : sign- or zero-extended immediate
//   rs, rt  : source register fields
//   uses_rt : instruction reads rt as a register operand
//   illegal : unsupported opcode/funct (instr == 0 is a legal bubble)
module alu_decoder
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output ex_ctrl_t        ctrl,
    output logic [XLEN-1:0] imm,
    output logic [REGW-1:0] rs,
    output logic [REGW-1:0] rt,
    output logic            uses_rt,
    output logic            illegal
);

    logic [5:0]      op;
    logic [5:0]      funct;
    logic [4:0]      shamt;
    logic [XLEN-1:0] sext;
    logic [XLEN-1:0] zext;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign shamt = instr[10:6];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign sext  = {{16{instr[15]}}, instr[15:0]};
    assign zext  = {16'h0000, instr[15:0]};

    // Decode table; illegal encodings collapse to a bubble payload.
    always_comb begin
        ctrl    = '0;
        imm     = '0;
        uses_rt = 1'b0;
        illegal = 1'b0;
        if (instr != '0) begin
            case (op)
                OP_RTYPE: begin
                    ctrl.regwrite = 1'b1;
                    ctrl.dst      = instr[15:11];
                    uses_rt       = 1'b1;
                    case (funct)
                        F_ADD, F_ADDU: ctrl.alucont = ALU_ADD;
                        F_SUB, F_SUBU: ctrl.alucont = ALU_SUB;
                        F_AND:         ctrl.alucont = ALU_AND;
                        F_OR:          ctrl.alucont = ALU_OR;
                        F_SLT:         ctrl.alucont = ALU_SLT;
                        default:       illegal      = 1'b1;
                    endcase
                    if (shamt != '0) illegal = 1'b1;
                end
                OP_LW: begin
                    ctrl.regwrite = 1'b1;
                    ctrl.memtoreg = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    ctrl.alucont  = ALU_ADD;
                    ctrl.dst      = rt;
                    imm           = sext;
                end
                OP_SW: begin
                    ctrl.memwrite = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    ctrl.alucont  = ALU_ADD;
                    imm           = sext;
                    uses_rt       = 1'b1;
                end
                OP_ADDI, OP_SLTI: begin
                    ctrl.regwrite = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    ctrl.alucont  = (op == OP_ADDI) ? ALU_ADD : ALU_SLT;
                    ctrl.dst      = rt;
                    imm           = sext;
                end
                OP_ANDI, OP_ORI: begin
                    ctrl.regwrite = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    ctrl.alucont  = (op == OP_ANDI) ? ALU_AND : ALU_OR;
                    ctrl.dst      = rt;
                    imm           = zext;
                end
                OP_BEQ: begin
                    ctrl.branch  = 1'b1;
                    ctrl.alucont = ALU_SUB;
                    imm          = sext;
                    uses_rt      = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
            if (illegal) begin
                ctrl    = '0;
                imm     = '0;
                uses_rt = 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode in ID, ID/EX pipeline register, load-use/stall/
// flush handling and EX-side operand forwarding.
//   id_*            : ID instruction and register-file data; id_ready = consumed
//   ex_stall/flush  : downstream hold / kill of ID/EX and the ID instruction
//   exmem_*/memwb_* : forwarding sources one/two instructions ahead
//   ex_*            : EX-stage control and forwarded operands
//   illegal_instr   : one-cycle pulse when an unsupported encoding is accepted
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_instr,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    output logic            id_ready,
    input  logic            ex_stall,
    input  logic            ex_flush,
    input  logic            exmem_regwrite,
    input  logic [REGW-1:0] exmem_dst,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_regwrite,
    input  logic [REGW-1:0] memwb_dst,
    input  logic [XLEN-1:0] memwb_result,
    output logic            ex_valid,
    output logic [2:0]      ex_alucont,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [REGW-1:0] ex_dst,
    output logic            ex_regwrite,
    output logic            ex_memtoreg,
    output logic            ex_memwrite,
    output logic            ex_branch,
    output logic            illegal_instr
);

    ex_ctrl_t        dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic [REGW-1:0] dec_rs;
    logic [REGW-1:0] dec_rt;
    logic            dec_uses_rt;
    logic            dec_illegal;

    ex_ctrl_t        ctrl_q;
    logic [REGW-1:0] rs_q;
    logic [REGW-1:0] rt_q;
    logic [XLEN-1:0] opa_q;
    logic [XLEN-1:0] opb_q;
    logic [XLEN-1:0] imm_q;

    logic            load_use;
    logic            accept;
    logic            id_live;
    logic [XLEN-1:0] cap_a;
    logic [XLEN-1:0] cap_b;
    logic [XLEN-1:0] rt_fwd;

    alu_decoder u_dec (
        .instr   (id_instr),
        .ctrl    (dec_ctrl),
        .imm     (dec_imm),
        .rs      (dec_rs),
        .rt      (dec_rt),
        .uses_rt (dec_uses_rt),
        .illegal (dec_illegal)
    );

    // A load in EX whose result the ID instruction needs cannot be forwarded in time.
    assign load_use = ex_valid && ctrl_q.memtoreg && (ctrl_q.dst != '0) &&
                      ((ctrl_q.dst == dec_rs) || (dec_uses_rt && (ctrl_q.dst == dec_rt)));
    assign accept   = !ex_flush && !ex_stall && !load_use;
    assign id_ready = !reset && (ex_flush || accept);
    assign id_live  = id_valid && !dec_illegal && (id_instr != '0);

    // Register-file write happening this cycle is not yet visible in id_rd1/id_rd2.
    assign cap_a = fwd_sel(dec_rs, id_rd1, 1'b0, '0, '0, memwb_regwrite, memwb_dst, memwb_result);
    assign cap_b = fwd_sel(dec_rt, id_rd2, 1'b0, '0, '0, memwb_regwrite, memwb_dst, memwb_result);

    // ID/EX register: flush > stall (hold) > load-use/idle bubble > capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ctrl_q        <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            imm_q         <= '0;
            illegal_instr <= 1'b0;
        end else begin
            illegal_instr <= accept && id_valid && dec_illegal;
            if (!ex_flush && ex_stall) begin
                ex_valid <= ex_valid;
            end else if (accept && id_live) begin
                ex_valid <= 1'b1;
                ctrl_q   <= dec_ctrl;
                rs_q     <= dec_rs;
                rt_q     <= dec_rt;
                opa_q    <= cap_a;
                opb_q    <= cap_b;
                imm_q    <= dec_imm;
            end else begin
                ex_valid <= 1'b0;
                ctrl_q   <= '0;
                rs_q     <= '0;
                rt_q     <= '0;
                opa_q    <= '0;
                opb_q    <= '0;
                imm_q    <= '0;
            end
        end
    end

    // EX operand forwarding.
    assign ex_a   = fwd_sel(rs_q, opa_q, exmem_regwrite, exmem_dst, exmem_result,
                            memwb_regwrite, memwb_dst, memwb_result);
    assign rt_fwd = fwd_sel(rt_q, opb_q, exmem_regwrite, exmem_dst, exmem_result,
                            memwb_regwrite, memwb_dst, memwb_result);
    assign ex_b          = ctrl_q.alusrc ? imm_q : rt_fwd;
    assign ex_store_data = rt_fwd;

    assign ex_alucont  = 3'(ctrl_q.alucont);
    assign ex_dst      = ctrl_q.dst;
    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_memtoreg = ctrl_q.memtoreg;
    assign ex_memwrite = ctrl_q.memwrite;
    assign ex_branch   = ctrl_q.branch;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage.
module tb_alu_issue_stage;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_rd1;
    logic [31:0] id_rd2;
    logic        id_ready;
    logic        ex_stall;
    logic        ex_flush;
    logic        exmem_regwrite;
    logic [4:0]  exmem_dst;
    logic [31:0] exmem_result;
    logic        memwb_regwrite;
    logic [4:0]  memwb_dst;
    logic [31:0] memwb_result;
    logic        ex_valid;
    logic [2:0]  ex_alucont;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_dst;
    logic        ex_regwrite;
    logic        ex_memtoreg;
    logic        ex_memwrite;
    logic        ex_branch;
    logic        illegal_instr;

    int n_cmp = 0;
    int n_bad = 0;

    alu_issue_stage dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_rd1         (id_rd1),
        .id_rd2         (id_rd2),
        .id_ready       (id_ready),
        .ex_stall       (ex_stall),
        .ex_flush       (ex_flush),
        .exmem_regwrite (exmem_regwrite),
        .exmem_dst      (exmem_dst),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_dst      (memwb_dst),
        .memwb_result   (memwb_result),
        .ex_valid       (ex_valid),
        .ex_alucont     (ex_alucont),
        .ex_a           (ex_a),
        .ex_b           (ex_b),
        .ex_store_data  (ex_store_data),
        .ex_dst         (ex_dst),
        .ex_regwrite    (ex_regwrite),
        .ex_memtoreg    (ex_memtoreg),
        .ex_memwrite    (ex_memwrite),
        .ex_branch      (ex_branch),
        .illegal_instr  (illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_instr = '0; id_rd1 = '0; id_rd2 = '0;
        ex_stall = 1'b0; ex_flush = 1'b0;
        exmem_regwrite = 1'b0; exmem_dst = '0; exmem_result = '0;
        memwb_regwrite = 1'b0; memwb_dst = '0; memwb_result = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        id_valid = 1'b1; id_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20); id_rd1 = 32'h5; id_rd2 = 32'h7;
        tick(); tick();
        idle();
        #1;
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
        n_cmp++; if (ex_alucont !== 3'b000) begin n_bad++; $display("FAIL reset_alucont: got %b want 000", ex_alucont); end
        n_cmp++; if (ex_dst !== 5'd0) begin n_bad++; $display("FAIL reset_dst: got %0d want 0", ex_dst); end
        n_cmp++; if (ex_regwrite !== 1'b0) begin n_bad++; $display("FAIL reset_regwrite: got %b want 0", ex_regwrite); end
        n_cmp++; if (ex_a !== 32'h0) begin n_bad++; $display("FAIL reset_ex_a: got %h want 0", ex_a); end
        n_cmp++; if (illegal_instr !== 1'b0) begin n_bad++; $display("FAIL reset_illegal: got %b want 0", illegal_instr); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add();
        idle();
        id_valid = 1'b1; id_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20); id_rd1 = 32'h5; id_rd2 = 32'h7;
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL add_id_ready: got %b want 1", id_ready); end
        tick();
        idle();
        #1;
        n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL add_ex_valid: got %b want 1", ex_valid); end
        n_cmp++; if (ex_alucont !== 3'b010) begin n_bad++; $display("FAIL add_alucont: got %b want 010", ex_alucont); end
        n_cmp++; if (ex_a !== 32'h5) begin n_bad++; $display("FAIL add_ex_a: got %h want 5", ex_a); end
        n_cmp++; if (ex_b !== 32'h7) begin n_bad++; $display("FAIL add_ex_b: got %h want 7", ex_b); end
        n_cmp++; if (ex_dst !== 5'd3) begin n_bad++; $display("FAIL add_dst: got %0d want 3", ex_dst); end
        n_cmp++; if (ex_regwrite !== 1'b1) begin n_bad++; $display("FAIL add_regwrite: got %b want 1", ex_regwrite); end
        tick();
    endtask

    task automatic test_load_use();
        idle();
        id_valid = 1'b1; id_instr = itype(6'h23, 5'd1, 5'd4, 16'h0000); id_rd1 = 32'h100;
        tick();
        id_instr = rtype(5'd4, 5'd4, 5'd5, 6'h20); id_rd1 = 32'hEEEE; id_rd2 = 32'hEEEE;
        #1;
        n_cmp++; if (ex_memtoreg !== 1'b1) begin n_bad++; $display("FAIL lw_memtoreg: got %b want 1", ex_memtoreg); end
        n_cmp++; if (ex_dst !== 5'd4) begin n_bad++; $display("FAIL lw_dst: got %0d want 4", ex_dst); end
        n_cmp++; if (ex_a !== 32'h100 || ex_b !== 32'h0) begin n_bad++; $display("FAIL lw_operands: got a=%h b=%h want a=100 b=0", ex_a, ex_b); end
        n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL lu_id_ready_stall: got %b want 0", id_ready); end
        tick();
        #1;
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL lu_bubble: got ex_valid=%b want 0", ex_valid); end
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL lu_id_ready_resume: got %b want 1", id_ready); end
        tick();
        idle();
        memwb_regwrite = 1'b1; memwb_dst = 5'd4; memwb_result = 32'h1234;
        #1;
        n_cmp++; if (ex_valid !== 1'b1 || ex_dst !== 5'd5) begin n_bad++; $display("FAIL lu_add_issue: got valid=%b dst=%0d want 1/5", ex_valid, ex_dst); end
        n_cmp++; if (ex_a !== 32'h1234) begin n_bad++; $display("FAIL lu_fwd_a: got %h want 1234", ex_a); end
        n_cmp++; if (ex_b !== 32'h1234) begin n_bad++; $display("FAIL lu_fwd_b: got %h want 1234", ex_b); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_forward();
        idle();
        id_valid = 1'b1; id_instr = rtype(5'd2, 5'd0, 5'd7, 6'h20); id_rd1 = 32'h11; id_rd2 = 32'h0;
        tick();
        idle();
        exmem_regwrite = 1'b1; exmem_dst = 5'd2; exmem_result = 32'hAA;
        memwb_regwrite = 1'b1; memwb_dst = 5'd2; memwb_result = 32'hBB;
        #1;
        n_cmp++; if (ex_a !== 32'hAA) begin n_bad++; $display("FAIL fwd_exmem_wins: got %h want aa", ex_a); end
        exmem_regwrite = 1'b0;
        #1;
        n_cmp++; if (ex_a !== 32'hBB) begin n_bad++; $display("FAIL fwd_memwb: got %h want bb", ex_a); end
        exmem_regwrite = 1'b1; exmem_dst = 5'd0; memwb_dst = 5'd0;
        #1;
        n_cmp++; if (ex_b !== 32'h0) begin n_bad++; $display("FAIL fwd_r0_blocked: got %h want 0", ex_b); end
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
        #1;
        n_cmp++; if (ex_a !== 32'h11) begin n_bad++; $display("FAIL fwd_stored: got %h want 11", ex_a); end
        id_valid = 1'b1; id_instr = rtype(5'd2, 5'd3, 5'd8, 6'h25); id_rd1 = 32'h11; id_rd2 = 32'h22;
        memwb_regwrite = 1'b1; memwb_dst = 5'd3; memwb_result = 32'hCC;
        tick();
        idle();
        #1;
        n_cmp++; if (ex_a !== 32'h11 || ex_b !== 32'hCC) begin n_bad++; $display("FAIL id_bypass: got a=%h b=%h want 11/cc", ex_a, ex_b); end
        n_cmp++; if (ex_alucont !== 3'b001) begin n_bad++; $display("FAIL or_alucont: got %b want 001", ex_alucont); end
        tick();
    endtask

    task automatic test_stall();
        idle();
        id_valid = 1'b1; id_instr = itype(6'h0A, 5'd1, 5'd6, 16'hFFFF); id_rd1 = 32'h9;
        tick();
        idle();
        id_valid = 1'b1; id_instr = rtype(5'd1, 5'd2, 5'd10, 6'h20); id_rd1 = 32'h1; id_rd2 = 32'h2;
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exmem_regwrite = (i == 1); exmem_dst = 5'd1; exmem_result = 32'h55;
            #1;
            n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL stall_id_ready[%0d]: got %b want 0", i, id_ready); end
            n_cmp++; if (ex_valid !== 1'b1 || ex_alucont !== 3'b111 || ex_dst !== 5'd6) begin n_bad++; $display("FAIL stall_hold[%0d]: got v=%b alu=%b dst=%0d want 1/111/6", i, ex_valid, ex_alucont, ex_dst); end
            n_cmp++; if (ex_b !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL stall_ex_b[%0d]: got %h want ffffffff", i, ex_b); end
            n_cmp++; if (ex_a !== ((i == 1) ? 32'h55 : 32'h9)) begin n_bad++; $display("FAIL stall_ex_a[%0d]: got %h want %h", i, ex_a, (i == 1) ? 32'h55 : 32'h9); end
            tick();
        end
        ex_stall = 1'b0; exmem_regwrite = 1'b0;
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready: got %b want 1", id_ready); end
        tick();
        idle();
        #1;
        n_cmp++; if (ex_dst !== 5'd10 || ex_alucont !== 3'b010) begin n_bad++; $display("FAIL stall_next_issue: got dst=%0d alu=%b want 10/010", ex_dst, ex_alucont); end
        tick();
    endtask

    task automatic test_flush();
        idle();
        id_valid = 1'b1; id_instr = itype(6'h23, 5'd1, 5'd4, 16'h0008); id_rd1 = 32'h10;
        tick();
        id_instr = rtype(5'd4, 5'd4, 5'd5, 6'h3F);
        ex_stall = 1'b1; ex_flush = 1'b1;
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL flush_id_ready: got %b want 1", id_ready); end
        tick();
        idle();
        #1;
        n_cmp++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_memwrite !== 1'b0) begin n_bad++; $display("FAIL flush_bubble: got v=%b rw=%b mw=%b want 0/0/0", ex_valid, ex_regwrite, ex_memwrite); end
        n_cmp++; if (illegal_instr !== 1'b0) begin n_bad++; $display("FAIL flush_no_illegal: got %b want 0", illegal_instr); end
        tick();
    endtask

    task automatic test_ori_illegal();
        idle();
        id_valid = 1'b1; id_instr = itype(6'h0D, 5'd0, 5'd1, 16'h8000);
        tick();
        id_instr = rtype(5'd1, 5'd2, 5'd3, 6'h3F);
        #1;
        n_cmp++; if (ex_b !== 32'h00008000) begin n_bad++; $display("FAIL ori_zext: got %h want 00008000", ex_b); end
        n_cmp++; if (ex_alucont !== 3'b001 || ex_dst !== 5'd1) begin n_bad++; $display("FAIL ori_ctrl: got alu=%b dst=%0d want 001/1", ex_alucont, ex_dst); end
        tick();
        idle();
        #1;
        n_cmp++; if (illegal_instr !== 1'b1) begin n_bad++; $display("FAIL illegal_pulse: got %b want 1", illegal_instr); end
        n_cmp++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0) begin n_bad++; $display("FAIL illegal_bubble: got v=%b rw=%b want 0/0", ex_valid, ex_regwrite); end
        tick();
        n_cmp++; if (illegal_instr !== 1'b0) begin n_bad++; $display("FAIL illegal_one_cycle: got %b want 0", illegal_instr); end
    endtask

    task automatic test_back_to_back();
        idle();
        id_valid = 1'b1; id_instr = itype(6'h2B, 5'd1, 5'd2, 16'h0004); id_rd1 = 32'h100; id_rd2 = 32'h77;
        tick();
        id_instr = itype(6'h04, 5'd1, 5'd2, 16'h0010); id_rd1 = 32'h3; id_rd2 = 32'h3;
        #1;
        n_cmp++; if (ex_memwrite !== 1'b1 || ex_regwrite !== 1'b0 || ex_dst !== 5'd0) begin n_bad++; $display("FAIL sw_ctrl: got mw=%b rw=%b dst=%0d want 1/0/0", ex_memwrite, ex_regwrite, ex_dst); end
        n_cmp++; if (ex_b !== 32'h4 || ex_store_data !== 32'h77 || ex_alucont !== 3'b010) begin n_bad++; $display("FAIL sw_data: got b=%h sd=%h alu=%b want 4/77/010", ex_b, ex_store_data, ex_alucont); end
        tick();
        id_instr = rtype(5'd1, 5'd2, 5'd9, 6'h22); id_rd1 = 32'hA; id_rd2 = 32'h4;
        #1;
        n_cmp++; if (ex_branch !== 1'b1 || ex_alucont !== 3'b110 || ex_dst !== 5'd0 || ex_b !== 32'h3) begin n_bad++; $display("FAIL beq: got br=%b alu=%b dst=%0d b=%h want 1/110/0/3", ex_branch, ex_alucont, ex_dst, ex_b); end
        tick();
        id_instr = itype(6'h0C, 5'd1, 5'd11, 16'hFFFF); id_rd1 = 32'hF0F0F0F0;
        #1;
        n_cmp++; if (ex_alucont !== 3'b110 || ex_dst !== 5'd9 || ex_a !== 32'hA || ex_b !== 32'h4) begin n_bad++; $display("FAIL sub: got alu=%b dst=%0d a=%h b=%h want 110/9/a/4", ex_alucont, ex_dst, ex_a, ex_b); end
        tick();
        idle();
        #1;
        n_cmp++; if (ex_alucont !== 3'b000 || ex_dst !== 5'd11 || ex_b !== 32'h0000FFFF) begin n_bad++; $display("FAIL andi: got alu=%b dst=%0d b=%h want 000/11/0000ffff", ex_alucont, ex_dst, ex_b); end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_add();
        test_load_use();
        test_forward();
        test_stall();
        test_flush();
        test_ori_illegal();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
